sample_scheduler: RTL and testbench
===================================

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the sensor sample width in bits.
REQ-002 Parameter AVG_LOG2, default 3, SHALL set the number of samples per average to 2^AVG_LOG2.
REQ-003 Parameter ACK_TIMEOUT, default 1000, SHALL set the clk cycles allowed from s_req rising to s_ack.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 tick  input  1  SHALL be a one-cycle sample-period strobe, driven by the upstream 50 ms timer ready output.
REQ-007 enable  input  1  SHALL gate the start of new acquisitions.
REQ-008 s_req  output  1  SHALL be the sensor read request (four-phase handshake).
REQ-009 s_ack  input  1  SHALL be the sensor acknowledge; s_data SHALL be valid while it is high.
REQ-010 s_data  input  DATA_W  SHALL be the unsigned sensor sample.
REQ-011 avg_out  output  DATA_W  SHALL be the last completed average, held between updates.
REQ-012 avg_valid  output  1  SHALL pulse high for one cycle when avg_out updates.
REQ-013 timeout_err  output  1  SHALL be a sticky flag for a missed acknowledge.
REQ-014 overrun  output  1  SHALL be a sticky flag for a tick that arrives while busy.
REQ-015 err_clr  input  1  SHALL clear timeout_err and overrun.

Function
REQ-016 The FSM SHALL have five states: IDLE, REQ, RELEASE, OUT and DROP.
REQ-017 In IDLE, tick=1 with enable=1 SHALL cause a move to REQ on the next edge; tick with enable=0 SHALL be ignored.
REQ-018 s_req SHALL be high in REQ only, with no combinational path from any input.
REQ-019 In REQ, s_ack=1 SHALL cause these actions on the same edge: add s_data to the accumulator, increment the sample count, and move to RELEASE.
REQ-020 In REQ, the wait counter SHALL reach ACK_TIMEOUT-1 with s_ack=0 to cause these actions: set timeout_err, discard the sample, leave the accumulator unchanged, and move to DROP.
REQ-021 s_ack=1 on the final timeout cycle SHALL be accepted as a valid acknowledge, and no timeout SHALL be flagged.
REQ-022 RELEASE and DROP SHALL wait for s_ack=0, then go to OUT if the count equals 2^AVG_LOG2, otherwise to IDLE; DROP SHALL always go to IDLE.
REQ-023 In OUT, the following SHALL occur: avg_out <= accumulator >> AVG_LOG2 (truncating), avg_valid=1 for exactly that cycle, and the accumulator and count cleared; the next state SHALL be IDLE.
REQ-024 The accumulator SHALL be DATA_W+AVG_LOG2 bits wide and SHALL never overflow; the count SHALL be AVG_LOG2+1 bits wide.
REQ-025 Latency from the acknowledge of the final sample to avg_valid SHALL be 2 cycles when s_ack drops one cycle after being sampled.
REQ-026 tick=1 in any state other than IDLE SHALL set overrun and SHALL NOT queue an acquisition.
REQ-027 When err_clr and a set condition occur in the same cycle, the set SHALL win.
REQ-028 Deasserting enable mid-acquisition SHALL let the current handshake complete; partial sums SHALL be retained across enable low.
REQ-029 The wait counter SHALL reset on every entry to REQ and SHALL saturate.

Reset
REQ-030 reset=1 SHALL asynchronously force the following: state=IDLE, s_req=0, avg_out=0, avg_valid=0, timeout_err=0, overrun=0, accumulator=0, count=0, wait counter=0.
REQ-031 Reset asserted mid-handshake SHALL drop s_req immediately, and the partial average SHALL be lost.
REQ-032 The first tick after reset release SHALL start a fresh 2^AVG_LOG2-sample average.

Structure
REQ-033 The FSM state enum and the default DATA_W and AVG_LOG2 constants SHALL live in the shared project package.
REQ-034 The acknowledge-timeout counter SHALL be a sub-module named ack_watchdog (inputs: start and ack; output: expired).

Verification
REQ-035 Eight ticks with s_ack answering after 3 cycles and data 100,102,...,114 -> exactly one avg_valid pulse with avg_out=107.
REQ-036 Eight ticks with data 4095 each -> avg_out=4095, with no accumulator wrap.
REQ-037 One tick with s_ack never asserted -> timeout_err=1 at cycle ACK_TIMEOUT after s_req rises, then s_req=0; the next seven good samples plus one more -> avg from the 8 good samples only.
REQ-038 s_ack asserted exactly on the last timeout cycle -> sample accepted and timeout_err stays 0.
REQ-039 Tick during REQ, then err_clr and a second overrun tick in the same cycle -> overrun=1 after both, and only one acquisition is performed.
REQ-040 Reset pulsed after 5 of 8 samples -> all outputs 0 immediately; the next 8 samples of 200 -> avg_out=200.

Source files
------------

// File: rtl/sample_scheduler_pkg.sv
// Shared constants and FSM encoding for the sample scheduler.
package sample_scheduler_pkg;

  localparam int unsigned DefaultDataW   = 12;
  localparam int unsigned DefaultAvgLog2 = 3;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StReq     = 3'd1;
  localparam state_t StRelease = 3'd2;
  localparam state_t StOut     = 3'd3;
  localparam state_t StDrop    = 3'd4;

endpackage

// File: rtl/sample_scheduler_ack_watchdog.sv
// Acknowledge watchdog: counts cycles since start, saturating at TIMEOUT-1.
module ack_watchdog #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (cnt_q != LastCnt) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // An acknowledge on the final cycle still wins over expiry.
  assign expired = (cnt_q == LastCnt) && !ack;

endmodule

// File: rtl/sample_scheduler.sv
// Periodic sensor acquisition with four-phase handshake, 2^AVG_LOG2 averaging
// and sticky timeout/overrun flags.
module sample_scheduler
  import sample_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned AVG_LOG2    = DefaultAvgLog2,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  output logic              s_req,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              timeout_err,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int unsigned AccW = DATA_W + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(2 ** AVG_LOG2);

  state_t            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              wd_start, wd_expired, timeout_set, overrun_set;

  ack_watchdog #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .ack     (s_ack),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    wd_start    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d  = StReq;
          wd_start = 1'b1;
        end
      end
      StReq: begin
        if (s_ack) begin
          acc_d   = acc_q + AccW'(s_data);
          cnt_d   = cnt_q + CntW'(1);
          state_d = StRelease;
        end else if (wd_expired) begin
          timeout_set = 1'b1;
          state_d     = StDrop;
        end
      end
      StRelease: begin
        if (!s_ack) begin
          state_d = (cnt_q == FullCnt) ? StOut : StIdle;
        end
      end
      StDrop: begin
        if (!s_ack) begin
          state_d = StIdle;
        end
      end
      StOut: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Load the average on entry so avg_out is already valid while avg_valid is high.
    if (state_d == StOut) begin
      avg_d = acc_q[AccW-1:AVG_LOG2];
    end

    overrun_set = tick && (state_q != StIdle);

    // Set beats clear when both happen in the same cycle.
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (err_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign s_req       = (state_q == StReq);
  assign avg_valid   = (state_q == StOut);
  assign avg_out     = avg_q;
  assign timeout_err = timeout_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: averaging, timeout, overrun and reset cases.
module tb_sample_scheduler;

  localparam int unsigned DW = 12;
  localparam int unsigned AL = 3;
  localparam int unsigned T  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick, enable, s_ack, err_clr;
  logic [DW-1:0] s_data;
  logic          s_req, avg_valid, timeout_err, overrun;
  logic [DW-1:0] avg_out;

  int tests  = 0;
  int failed = 0;
  int pulses = 0;
  int reqs   = 0;
  logic [DW-1:0] last_avg = '0;
  logic prev_req = 1'b0;
  logic v;
  int req_base;

  sample_scheduler #(
    .DATA_W      (DW),
    .AVG_LOG2    (AL),
    .ACK_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .s_req       (s_req),
    .s_ack       (s_ack),
    .s_data      (s_data),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (avg_valid) begin
      pulses   <= pulses + 1;
      last_avg <= avg_out;
    end
    if (s_req && !prev_req) reqs <= reqs + 1;
    prev_req <= s_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns avg_valid two edges after the ack edge.
  task automatic send_sample(input logic [DW-1:0] data, input int delay, output logic vl);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("req_up", s_req, 1);
    repeat (delay) @(negedge clk);
    s_ack  = 1'b1;
    s_data = data;
    @(negedge clk);
    s_ack = 1'b0;
    @(negedge clk);
    vl = avg_valid;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b1; s_ack = 1'b0; err_clr = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_sreq", s_req, 0);
    check_eq("rst_avg", avg_out, 0);
    check_eq("rst_valid", avg_valid, 0);
    check_eq("rst_tmo", timeout_err, 0);
    check_eq("rst_ovr", overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    // Tick with enable low is ignored.
    enable = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("dis_sreq", s_req, 0);
    enable = 1'b1;
    @(negedge clk);

    // 100..114 -> 107, valid two edges after final ack.
    for (int i = 0; i < 8; i++) begin
      send_sample(DW'(100 + 2 * i), 3, v);
      check_eq("lat_valid", v, (i == 7) ? 1 : 0);
    end
    check_eq("avg1_pulses", pulses, 1);
    check_eq("avg1_val", last_avg, 107);
    check_eq("avg1_tmo", timeout_err, 0);
    check_eq("avg1_ovr", overrun, 0);

    // Full scale, no wrap.
    for (int i = 0; i < 8; i++) send_sample(12'd4095, 1, v);
    check_eq("max_pulses", pulses, 2);
    check_eq("max_val", last_avg, 4095);

    // Missed acknowledge.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (T - 1) @(negedge clk);
    check_eq("tmo_early", timeout_err, 0);
    check_eq("tmo_early_req", s_req, 1);
    @(negedge clk);
    check_eq("tmo_set", timeout_err, 1);
    check_eq("tmo_req_drop", s_req, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) send_sample(DW'(10 * (i + 1)), 2, v);
    check_eq("tmo_7_pulses", pulses, 2);
    send_sample(12'd80, 2, v);
    check_eq("tmo_pulses", pulses, 3);
    check_eq("tmo_avg", last_avg, 45);
    check_eq("tmo_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("tmo_clr", timeout_err, 0);

    // Acknowledge on the last allowed cycle.
    send_sample(12'd800, T - 1, v);
    check_eq("edge_tmo", timeout_err, 0);
    for (int i = 0; i < 7; i++) send_sample(12'd800, 1, v);
    check_eq("edge_pulses", pulses, 4);
    check_eq("edge_avg", last_avg, 800);

    // Overrun, then clear and set together.
    req_base = reqs;
    tick = 1'b1;
    @(negedge clk);
    check_eq("ovr_req", s_req, 1);
    @(negedge clk);
    tick = 1'b0;
    check_eq("ovr_set", overrun, 1);
    tick = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    tick = 1'b0; err_clr = 1'b0;
    check_eq("ovr_set_wins", overrun, 1);
    s_ack = 1'b1; s_data = 12'd500;
    @(negedge clk);
    s_ack = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("ovr_one_acq", reqs - req_base, 1);
    check_eq("ovr_sticky", overrun, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("ovr_clr", overrun, 0);

    // Partial average lost on reset mid-handshake.
    for (int i = 0; i < 5; i++) send_sample(12'd999, 1, v);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    check_eq("pre_rst_ovr", overrun, 1);
    reset = 1'b1;
    #1;
    check_eq("arst_sreq", s_req, 0);
    check_eq("arst_avg", avg_out, 0);
    check_eq("arst_valid", avg_valid, 0);
    check_eq("arst_ovr", overrun, 0);
    check_eq("arst_tmo", timeout_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send_sample(12'd200, 2, v);
    check_eq("post_rst_pulses", pulses, 5);
    check_eq("post_rst_avg", last_avg, 200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
